// File: rtl/kj_circular_buffer.sv
// K-in / J-out circular buffer with ready/valid handshakes and internal addressing.
// Beats may straddle the end of the buffer; lanes continue at index 0 in order.
module kj_circular_buffer #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned K     = 4,
    parameter int unsigned J     = 8,
    parameter int unsigned CW    = $clog2(SIZE + 1),
    parameter int unsigned PW    = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [WIDTH*K-1:0] par_in,
    output logic               wr_ready,
    output logic               wr_err,
    input  logic               rd_en,
    output logic               rd_ready,
    output logic [WIDTH*J-1:0] par_out,
    output logic               out_valid,
    output logic [CW-1:0]      count
);

    localparam int unsigned SW = PW + 1;

    logic [WIDTH-1:0]   mem [SIZE];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_idx [K];
    logic [PW-1:0]      rd_idx [J];
    logic [PW-1:0]      wr_ptr_nxt;
    logic [PW-1:0]      rd_ptr_nxt;
    logic [SW-1:0]      wr_sum [K];
    logic [SW-1:0]      rd_sum [J];
    logic [SW-1:0]      wr_adv;
    logic [SW-1:0]      rd_adv;
    logic [WIDTH*J-1:0] rd_data;
    logic [CW-1:0]      count_nxt;
    logic               wr_fire;
    logic               rd_fire;

    // Readiness is judged on the pre-cycle occupancy only (no pass-through credit).
    assign wr_ready = (CW'(SIZE) - count) >= CW'(K);
    assign rd_ready = count >= CW'(J);
    assign wr_fire  = wr_en & wr_ready;
    assign rd_fire  = rd_en & rd_ready;

    // Lane addresses and pointer advance via compare-subtract modulo; any SIZE works.
    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            wr_sum[i] = {1'b0, wr_ptr} + SW'(i);
            wr_idx[i] = (wr_sum[i] >= SW'(SIZE)) ? PW'(wr_sum[i] - SW'(SIZE)) : PW'(wr_sum[i]);
        end
        for (int unsigned i = 0; i < J; i++) begin
            rd_sum[i] = {1'b0, rd_ptr} + SW'(i);
            rd_idx[i] = (rd_sum[i] >= SW'(SIZE)) ? PW'(rd_sum[i] - SW'(SIZE)) : PW'(rd_sum[i]);
        end
        wr_adv     = {1'b0, wr_ptr} + SW'(K);
        rd_adv     = {1'b0, rd_ptr} + SW'(J);
        wr_ptr_nxt = (wr_adv >= SW'(SIZE)) ? PW'(wr_adv - SW'(SIZE)) : PW'(wr_adv);
        rd_ptr_nxt = (rd_adv >= SW'(SIZE)) ? PW'(rd_adv - SW'(SIZE)) : PW'(rd_adv);
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < J; i++) begin
            rd_data[WIDTH*i +: WIDTH] = mem[rd_idx[i]];
        end
    end

    assign count_nxt = count + (wr_fire ? CW'(K) : CW'(0)) - (rd_fire ? CW'(J) : CW'(0));

    // Storage is never cleared; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_fire) begin
            for (int unsigned i = 0; i < K; i++) begin
                mem[wr_idx[i]] <= par_in[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            par_out   <= '0;
            out_valid <= 1'b0;
            wr_err    <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_fire) begin
                rd_ptr  <= rd_ptr_nxt;
                par_out <= rd_data;
            end
            count     <= count_nxt;
            out_valid <= rd_fire;
            wr_err    <= wr_en & ~wr_ready;
        end
    end

endmodule

// File: doc/kj_circular_buffer.md
Name: kj_circular_buffer

Overview:
- Parametrised circular buffer of SIZE entries, each WIDTH bits.
- Accepts K entries per write beat and returns J entries per read beat, with explicit ready/valid handshakes, occupancy tracking and wrap-around of any SIZE.
- Successor to the basic ld-driven K-in/J-out buffer. Addressing is internal (no external write/read addresses).
- Sits between the K-lane address generator/selector path and the J-lane consumer.

Parameters:
- SIZE, 16, number of WIDTH-bit entries. Any integer >= max(K,J); power of two not required.
- WIDTH, 8, bits per entry.
- K, 4, entries written per accepted write beat, 1..SIZE.
- J, 8, entries read per accepted read beat, 1..SIZE.
- CW, $clog2(SIZE+1), width of count.
- PW, $clog2(SIZE), width of internal pointers.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of pointers/count; memory contents untouched.
- wr_en  input  1  write request.
- par_in  input  WIDTH*K  K entries; lane i at [WIDTH*i +: WIDTH]; lane 0 is oldest.
- wr_ready  output  1  combinational: (SIZE - count) >= K.
- wr_err  output  1  registered one-cycle pulse: wr_en was high while wr_ready was low.
- rd_en  input  1  read request.
- rd_ready  output  1  combinational: count >= J.
- par_out  output  WIDTH*J  J entries; lane 0 is oldest; registered.
- out_valid  output  1  registered; high for one cycle after each accepted read.
- count  output  CW  current occupancy, in entries.

Behaviour:
- Reset (rst=1) values: wr_ptr=0, rd_ptr=0, count=0, par_out=0, out_valid=0, wr_err=0. Therefore wr_ready=1 and rd_ready=0. Memory is not cleared.
- rst has priority over flush.
- flush=1: wr_ptr=rd_ptr=count=0 and out_valid=0. Any wr_en/rd_en in the same cycle is ignored. wr_err=0. par_out holds its value.
- Write accept: wr_fire = wr_en & wr_ready.
  - mem[(wr_ptr+i) mod SIZE] <= par_in lane i, for i = 0..K-1.
  - wr_ptr <= (wr_ptr+K) mod SIZE.
- Read accept: rd_fire = rd_en & rd_ready.
  - par_out lane i <= mem[(rd_ptr+i) mod SIZE], for i = 0..J-1.
  - rd_ptr <= (rd_ptr+J) mod SIZE.
  - out_valid <= 1; out_valid <= 0 on any cycle without rd_fire.
- Latency: data appears on par_out one cycle after rd_fire. par_out holds its value until the next rd_fire.
- Modulo: computed as compare-subtract (p+n >= SIZE ? p+n-SIZE : p+n). No divider. Must be correct for non-power-of-two SIZE.
- Wrap-around: a beat may straddle the end of the buffer. Lanes continue at index 0 in order.
- count <= count + (wr_fire ? K : 0) - (rd_fire ? J : 0). Never exceeds SIZE; never goes negative.
- Simultaneous read and write:
  - Both readiness flags are evaluated on pre-cycle count. There is no pass-through credit: a full buffer rejects a write even when a read fires in the same cycle.
  - Read data is taken from pre-cycle memory. Since rd_ptr..rd_ptr+J-1 are occupied and wr_ptr..wr_ptr+K-1 are free, the two never alias.
- Rejected write: memory, wr_ptr and count unchanged; wr_err pulses next cycle.
- Rejected read (rd_en & !rd_ready): no state change, out_valid=0, no error flag.
- Inputs are sampled only on clk edges. X on par_in while wr_en=0 must not propagate.

Test Plan:
Defaults: SIZE=16, WIDTH=8, K=4, J=8. Entry value = sequence number.
1. Reset: assert rst 2 cycles with wr_en=rd_en=1 -> count=0, wr_ready=1, rd_ready=0, par_out=0, out_valid=0, wr_err=0.
2. Basic: write 0x03020100 then 0x07060504 -> count=8, rd_ready=1. Pulse rd_en -> next cycle par_out=0x0706050403020100, out_valid=1. Following cycle out_valid=0, count=0.
3. Full: 4 writes -> count=16, wr_ready=0. A 5th write (0xDEADBEEF) -> wr_err=1 for one cycle, count=16. Two subsequent reads return entries 0..15, 0xDEADBEEF absent.
4. Wrap:
   - Write values 0..11 -> count=12. Read -> 0x0706050403020100, count=4.
   - Write 12..19 (lands at indices 12..15 and 0..3) -> count=12.
   - Read -> par_out=0x0F0E0D0C0B0A0908, count=4. rd_ready=0.
   - A further rd_en leaves out_valid=0.
5. Simultaneous:
   - At count=8, wr_en&rd_en -> both accepted, count=4.
   - At count=16, wr_en&rd_en -> read accepted, write rejected (wr_err=1), count=8.
6. Mid-operation clear:
   - flush at count=12 together with wr_en -> count=0, out_valid=0, write ignored. Next write+read cycle sequence restarts at index 0.
   - Repeat with rst. Repeat with SIZE=12, K=3, J=5: write 4 beats, read 2 beats -> wrap ordering correct, count=2.
